alu_operand_stage: RTL and testbench

//  Operand-fetch/issue stage directly upstream of the ALU. Takes decoded ops, reads
//  the register file, forwards write-back data, stalls on a per-register scoreboard
//  and drives Data_1/Data_2/ALU_Op. Outputs are registered on posedge Fast_Clock;
//  the ALU samples them on the following negedge.

---
 rtl/alu_operand_stage.sv | 148 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// Operand-fetch/issue stage ahead of the ALU: register read with write-back forwarding,
// per-register pending scoreboard, divide-by-zero squash and a single registered output slot.
module alu_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 32
) (
  input  logic              Fast_Clock,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [4:0]        In_Op,
  input  logic [4:0]        In_Rs,
  input  logic [4:0]        In_Rt,
  input  logic [4:0]        In_Rd,
  input  logic              In_Use_Imm,
  input  logic [DATA_W-1:0] In_Imm,
  output logic [4:0]        RF_Addr_1,
  output logic [4:0]        RF_Addr_2,
  input  logic [DATA_W-1:0] RF_Data_1,
  input  logic [DATA_W-1:0] RF_Data_2,
  input  logic              WB_Write_En,
  input  logic [4:0]        WB_Addr,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [DATA_W-1:0] Data_1,
  output logic [DATA_W-1:0] Data_2,
  output logic [4:0]        ALU_Op,
  output logic [4:0]        Out_Dest,
  output logic              Div_Zero
);

  typedef enum logic [4:0] {
    OP_DIV   = 5'd3,
    OP_MOD   = 5'd4,
    OP_NO_RT = 5'd8,
    OP_NOP   = 5'd17,
    OP_IMM   = 5'd18
  } op_e;

  logic [REG_N-1:0]  pend_q, pend_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
  logic [4:0]        op_q, op_d, dest_q, dest_d;
  logic              dz_q, dz_d;
  logic              writer_q, writer_d;

  logic [4:0]        op_eff;
  logic              rs_used, rt_used, writes;
  logic              fwd_rs, fwd_rt, fwd_rd;
  logic [DATA_W-1:0] opnd1, opnd2;
  logic              div_zero, hazard, slot_free, accept;

  assign RF_Addr_1 = In_Rs;
  assign RF_Addr_2 = In_Rt;

  always_comb begin
    op_eff   = (In_Op > OP_IMM) ? OP_NOP : In_Op;
    rs_used  = !(op_eff == OP_NOP || op_eff == OP_IMM);
    rt_used  = !In_Use_Imm && !(op_eff == OP_NO_RT || op_eff == OP_NOP || op_eff == OP_IMM);
    writes   = (op_eff != OP_NOP) && (In_Rd != '0);

    fwd_rs   = WB_Write_En && (WB_Addr == In_Rs);
    fwd_rt   = WB_Write_En && (WB_Addr == In_Rt);
    fwd_rd   = WB_Write_En && (WB_Addr == In_Rd);

    opnd1    = (In_Rs == '0) ? '0 : (fwd_rs ? WB_Data : RF_Data_1);
    if (In_Use_Imm)
      opnd2  = In_Imm;
    else
      opnd2  = (In_Rt == '0) ? '0 : (fwd_rt ? WB_Data : RF_Data_2);

    div_zero = (op_eff == OP_DIV || op_eff == OP_MOD) && (opnd2 == '0);

    // A write-back landing this cycle resolves the hazard it would otherwise cause.
    hazard   = (rs_used && pend_q[In_Rs] && !fwd_rs)
            || (rt_used && pend_q[In_Rt] && !fwd_rt)
            || (writes  && pend_q[In_Rd] && !fwd_rd);

    slot_free = !valid_q || Out_Ready;
    In_Ready  = slot_free && !hazard && !Flush;
    accept    = In_Valid && In_Ready;
  end

  always_comb begin
    pend_d   = pend_q;
    valid_d  = valid_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    op_d     = op_q;
    dest_d   = dest_q;
    dz_d     = dz_q;
    writer_d = writer_q;

    // Clears first so a same-cycle set by an accept takes priority.
    if (WB_Write_En)
      pend_d[WB_Addr] = 1'b0;
    if (Flush && valid_q && writer_q)
      pend_d[dest_q] = 1'b0;

    if (accept) begin
      valid_d  = 1'b1;
      data1_d  = opnd1;
      data2_d  = opnd2;
      op_d     = div_zero ? OP_NOP : op_eff;
      dest_d   = In_Rd;
      dz_d     = div_zero;
      writer_d = writes && !div_zero;
      if (writes && !div_zero)
        pend_d[In_Rd] = 1'b1;
    end else if (Flush || Out_Ready) begin
      valid_d  = 1'b0;
    end

    pend_d[0] = 1'b0;
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      pend_q   <= '0;
      valid_q  <= 1'b0;
      data1_q  <= '0;
      data2_q  <= '0;
      op_q     <= OP_NOP;
      dest_q   <= '0;
      dz_q     <= 1'b0;
      writer_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      dz_q     <= dz_d;
      writer_q <= writer_d;
    end
  end

  assign Out_Valid = valid_q;
  assign Data_1    = data1_q;
  assign Data_2    = data2_q;
  assign ALU_Op    = op_q;
  assign Out_Dest  = dest_q;
  assign Div_Zero  = dz_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus randomized traffic
// compared against a behavioural model of the issue stage.
module tb_alu_operand_stage;

  logic        Fast_Clock = 1'b0;
  logic        Reset;
  logic        In_Valid, In_Ready;
  logic [4:0]  In_Op, In_Rs, In_Rt, In_Rd;
  logic        In_Use_Imm;
  logic [31:0] In_Imm;
  logic [4:0]  RF_Addr_1, RF_Addr_2;
  logic [31:0] RF_Data_1, RF_Data_2;
  logic        WB_Write_En;
  logic [4:0]  WB_Addr;
  logic [31:0] WB_Data;
  logic        Flush, Out_Valid, Out_Ready;
  logic [31:0] Data_1, Data_2;
  logic [4:0]  ALU_Op, Out_Dest;
  logic        Div_Zero;

  int checks = 0;
  int failures = 0;

  logic [31:0] rf [32];
  assign RF_Data_1 = rf[RF_Addr_1];
  assign RF_Data_2 = rf[RF_Addr_2];

  always #5 Fast_Clock = ~Fast_Clock;

  alu_operand_stage #(.DATA_W(32), .REG_N(32)) dut (
    .Fast_Clock(Fast_Clock), .Reset(Reset),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Op(In_Op),
    .In_Rs(In_Rs), .In_Rt(In_Rt), .In_Rd(In_Rd),
    .In_Use_Imm(In_Use_Imm), .In_Imm(In_Imm),
    .RF_Addr_1(RF_Addr_1), .RF_Addr_2(RF_Addr_2),
    .RF_Data_1(RF_Data_1), .RF_Data_2(RF_Data_2),
    .WB_Write_En(WB_Write_En), .WB_Addr(WB_Addr), .WB_Data(WB_Data),
    .Flush(Flush), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Data_1(Data_1), .Data_2(Data_2), .ALU_Op(ALU_Op),
    .Out_Dest(Out_Dest), .Div_Zero(Div_Zero)
  );

  // Reference model: set of in-flight destinations plus the held instruction.
  typedef struct {
    logic        valid;
    logic [31:0] d1, d2;
    logic [4:0]  op, dest;
    logic        dz, wr;
  } held_t;

  bit    m_busy [32];
  bit    n_busy [32];
  held_t m_held, n_held;
  logic  m_ready;

  function automatic logic wb_hits(input logic [4:0] r);
    return WB_Write_En && (WB_Addr == r);
  endfunction

  function automatic logic [31:0] read_src(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_hits(r)) return WB_Data;
    return rf[r];
  endfunction

  function automatic logic blocked(input logic [4:0] r);
    return m_busy[r] && !wb_hits(r);
  endfunction

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_held = '{valid: 1'b0, d1: 32'd0, d2: 32'd0, op: 5'd17, dest: 5'd0, dz: 1'b0, wr: 1'b0};
  endtask

  task automatic model_eval();
    int op;
    logic uses_rs, uses_rt, is_writer, zero_div, haz;
    logic [31:0] b;
    op        = (In_Op > 18) ? 17 : int'(In_Op);
    uses_rs   = !(op inside {17, 18});
    uses_rt   = !In_Use_Imm && !(op inside {8, 17, 18});
    is_writer = (op != 17) && (In_Rd != 0);
    haz = (uses_rs && blocked(In_Rs)) || (uses_rt && blocked(In_Rt)) || (is_writer && blocked(In_Rd));
    m_ready = (!m_held.valid || Out_Ready) && !haz && !Flush;
    b = In_Use_Imm ? In_Imm : read_src(In_Rt);
    zero_div = (op inside {3, 4}) && (b == 0);
    n_busy = m_busy;
    n_held = m_held;
    if (WB_Write_En) n_busy[WB_Addr] = 1'b0;
    if (Flush && m_held.valid && m_held.wr) n_busy[m_held.dest] = 1'b0;
    if (In_Valid && m_ready) begin
      n_held.valid = 1'b1;
      n_held.d1    = read_src(In_Rs);
      n_held.d2    = b;
      n_held.op    = zero_div ? 5'd17 : 5'(op);
      n_held.dest  = In_Rd;
      n_held.dz    = zero_div;
      n_held.wr    = is_writer && !zero_div;
      if (is_writer && !zero_div) n_busy[In_Rd] = 1'b1;
    end else if (Flush || Out_Ready) begin
      n_held.valid = 1'b0;
    end
    n_busy[0] = 1'b0;
  endtask

  task automatic model_commit();
    m_busy = n_busy;
    m_held = n_held;
    if (WB_Write_En && WB_Addr != 0) rf[WB_Addr] = WB_Data;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic imm_en, input logic [31:0] imm,
                        input logic valid);
    In_Op = op; In_Rs = rs; In_Rt = rt; In_Rd = rd;
    In_Use_Imm = imm_en; In_Imm = imm; In_Valid = valid;
  endtask

  // Settle, sample In_Ready, clock once, leave time at posedge+1.
  task automatic step(output logic rdy);
    #1;
    rdy = In_Ready;
    model_eval();
    @(posedge Fast_Clock);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    logic rdy;
    set_op(5'd0, 5'd1, 5'd2, 5'd9, 1'b0, 32'd0, 1'b1);
    Out_Ready = 1'b1;
    step(rdy);
    Out_Ready = 1'b0;
    set_op(5'd1, 5'd9, 5'd2, 5'd10, 1'b0, 32'd0, 1'b1);
    step(rdy);
    Reset = 1'b1;
    #2;
    checks++;
    if (Out_Valid !== 1'b0 || Data_1 !== 32'd0 || Data_2 !== 32'd0 || ALU_Op !== 5'd17 ||
        Out_Dest !== 5'd0 || Div_Zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d1=%h d2=%h op=%0d dest=%0d dz=%b exp v=0 d1=0 d2=0 op=17 dest=0 dz=0",
               Out_Valid, Data_1, Data_2, ALU_Op, Out_Dest, Div_Zero);
    end
    model_reset();
    @(posedge Fast_Clock);
    #1;
    Reset = 1'b0;
    set_op(5'd0, 5'd9, 5'd0, 5'd9, 1'b0, 32'd0, 1'b0);
    #1;
    checks++;
    if (In_Ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", In_Ready);
    end
  endtask

  task automatic test_add();
    logic rdy;
    rf[1] = 32'd5; rf[2] = 32'd7;
    Out_Ready = 1'b1;
    set_op(5'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0, 1'b1);
    #1;
    checks++;
    if (RF_Addr_1 !== 5'd1 || RF_Addr_2 !== 5'd2) begin
      failures++;
      $display("FAIL rf_addr got=%0d,%0d exp=1,2", RF_Addr_1, RF_Addr_2);
    end
    step(rdy);
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL add_ready got=%b exp=1", rdy); end
    checks++;
    if (Out_Valid !== 1'b1 || Data_1 !== 32'd5 || Data_2 !== 32'd7 || ALU_Op !== 5'd0 ||
        Out_Dest !== 5'd3 || Div_Zero !== 1'b0) begin
      failures++;
      $display("FAIL add_out got v=%b d1=%0d d2=%0d op=%0d dest=%0d dz=%b exp v=1 d1=5 d2=7 op=0 dest=3 dz=0",
               Out_Valid, Data_1, Data_2, ALU_Op, Out_Dest, Div_Zero);
    end
  endtask

  task automatic test_forward();
    logic rdy;
    set_op(5'd1, 5'd3, 5'd1, 5'd4, 1'b0, 32'd0, 1'b1);
    step(rdy);
    checks++;
    if (rdy !== 1'b0) begin failures++; $display("FAIL sub_stall got=%b exp=0", rdy); end
    WB_Write_En = 1'b1; WB_Addr = 5'd3; WB_Data = 32'd12;
    step(rdy);
    WB_Write_En = 1'b0;
    checks++;
    if (rdy !== 1'b1) begin failures++; $display("FAIL sub_wb_ready got=%b exp=1", rdy); end
    checks++;
    if (Out_Valid !== 1'b1 || Data_1 !== 32'd12 || Data_2 !== 32'd5 || ALU_Op !== 5'd1 ||
        Out_Dest !== 5'd4) begin
      failures++;
      $display("FAIL sub_fwd got v=%b d1=%0d d2=%0d op=%0d dest=%0d exp v=1 d1=12 d2=5 op=1 dest=4",
               Out_Valid, Data_1, Data_2, ALU_Op, Out_Dest);
    end
    set_op(5'd0, 5'd3, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    #1;
    checks++;
    if (In_Ready !== 1'b1) begin failures++; $display("FAIL r3_cleared got=%b exp=1", In_Ready); end
  endtask

  task automatic test_div_zero();
    logic rdy;
    set_op(5'd3, 5'd1, 5'd0, 5'd5, 1'b0, 32'd0, 1'b1);
    step(rdy);
    checks++;
    if (rdy !== 1'b1 || Out_Valid !== 1'b1 || ALU_Op !== 5'd17 || Div_Zero !== 1'b1 ||
        Out_Dest !== 5'd5) begin
      failures++;
      $display("FAIL div_zero got rdy=%b v=%b op=%0d dz=%b dest=%0d exp rdy=1 v=1 op=17 dz=1 dest=5",
               rdy, Out_Valid, ALU_Op, Div_Zero, Out_Dest);
    end
    set_op(5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    #1;
    checks++;
    if (In_Ready !== 1'b1) begin failures++; $display("FAIL div_no_pending got=%b exp=1", In_Ready); end
  endtask

  task automatic test_stall_flush();
    logic rdy;
    set_op(5'd2, 5'd1, 5'd2, 5'd6, 1'b0, 32'd0, 1'b1);
    step(rdy);
    Out_Ready = 1'b0;
    set_op(5'd0, 5'd1, 5'd2, 5'd10, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(rdy);
      checks++;
      if (rdy !== 1'b0 || Out_Valid !== 1'b1 || Data_1 !== 32'd5 || Data_2 !== 32'd7 ||
          ALU_Op !== 5'd2 || Out_Dest !== 5'd6 || Div_Zero !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d] got rdy=%b v=%b d1=%0d d2=%0d op=%0d dest=%0d exp rdy=0 v=1 d1=5 d2=7 op=2 dest=6",
                 i, rdy, Out_Valid, Data_1, Data_2, ALU_Op, Out_Dest);
      end
    end
    Flush = 1'b1; Out_Ready = 1'b1;
    step(rdy);
    Flush = 1'b0; Out_Ready = 1'b0;
    checks++;
    if (rdy !== 1'b0 || Out_Valid !== 1'b0) begin
      failures++;
      $display("FAIL flush got rdy=%b v=%b exp rdy=0 v=0", rdy, Out_Valid);
    end
    set_op(5'd0, 5'd6, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    #1;
    checks++;
    if (In_Ready !== 1'b1) begin failures++; $display("FAIL flush_clears_pending got=%b exp=1", In_Ready); end
  endtask

  task automatic test_imm();
    logic rdy;
    Out_Ready = 1'b1;
    set_op(5'd0, 5'd1, 5'd2, 5'd7, 1'b0, 32'd0, 1'b1);
    step(rdy);
    set_op(5'd18, 5'd7, 5'd0, 5'd8, 1'b1, 32'hDEAD_BEEF, 1'b1);
    step(rdy);
    checks++;
    if (rdy !== 1'b1 || Data_2 !== 32'hDEAD_BEEF || ALU_Op !== 5'd18 || Out_Valid !== 1'b1) begin
      failures++;
      $display("FAIL imm got rdy=%b d2=%h op=%0d v=%b exp rdy=1 d2=deadbeef op=18 v=1",
               rdy, Data_2, ALU_Op, Out_Valid);
    end
  endtask

  task automatic test_random();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 32; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      In_Op = 5'($urandom_range(19, 31));
      else if (r < 3)  In_Op = 5'($urandom_range(3, 4));
      else             In_Op = 5'($urandom_range(0, 18));
      In_Rs = 5'($urandom_range(0, 5));
      In_Rt = 5'($urandom_range(0, 5));
      In_Rd = 5'($urandom_range(0, 5));
      In_Use_Imm  = ($urandom_range(0, 3) == 0);
      In_Imm      = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      In_Valid    = ($urandom_range(0, 4) != 0);
      WB_Write_En = ($urandom_range(0, 2) == 0);
      WB_Addr     = 5'($urandom_range(0, 5));
      WB_Data     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      Flush       = ($urandom_range(0, 9) == 0);
      Out_Ready   = ($urandom_range(0, 9) < 7);
      #1;
      model_eval();
      checks++;
      if (In_Ready !== m_ready) begin
        failures++;
        $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, In_Ready, m_ready);
      end
      @(posedge Fast_Clock);
      model_commit();
      #1;
      checks++;
      if (Out_Valid !== m_held.valid || Data_1 !== m_held.d1 || Data_2 !== m_held.d2 ||
          ALU_Op !== m_held.op || Out_Dest !== m_held.dest || Div_Zero !== m_held.dz) begin
        failures++;
        $display("FAIL rnd_out[%0d] got v=%b d1=%h d2=%h op=%0d dest=%0d dz=%b exp v=%b d1=%h d2=%h op=%0d dest=%0d dz=%b",
                 n, Out_Valid, Data_1, Data_2, ALU_Op, Out_Dest, Div_Zero,
                 m_held.valid, m_held.d1, m_held.d2, m_held.op, m_held.dest, m_held.dz);
      end
    end
    WB_Write_En = 1'b0; Flush = 1'b0; In_Valid = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    WB_Write_En = 1'b0; WB_Addr = '0; WB_Data = '0;
    Flush = 1'b0; Out_Ready = 1'b1;
    set_op(5'd17, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
    rf[0] = 32'hFFFF_FFFF;
    model_reset();
    repeat (3) @(posedge Fast_Clock);
    #1;
    Reset = 1'b0;
    test_reset();
    test_add();
    test_forward();
    test_div_zero();
    test_stall_flush();
    test_imm();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
